fx2_fft_bridge: RTL and testbench
=================================

Name: fx2_fft_bridge

Overview:
- Successor to the first-generation FX2-to-FFT USB interface: synchronous slave-FIFO master between a Cypress FX2 (16-bit bus) and the parametrised FFT core.
- Loads twiddle weights once after reset, then streams complex input frames to the FFT and results back to the host.
- New over the previous generation: flag-qualified beats, parametrised word width, endpoint addresses and turnaround delay, complex (real+imag) word pairs, din valid/busy handshake, PKTEND per output frame.

Parameters:
- NPOINT, 3, log2 of FFT points; frame = 2**NPOINT complex points.
- DW, 16, sample/word width; must equal FX2 bus width.
- RD_EP, 2'b00, fx2_a value for host-to-device (OUT) FIFO.
- WR_EP, 2'b10, fx2_a value for device-to-host (IN) FIFO.
- SETTLE, 3, idle cycles after fx2_a change before first strobe (1..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- fx2_flaga  in  1  RD_EP FIFO not-empty (1 = data available)
- fx2_flagb  in  1  WR_EP FIFO not-full (1 = space available)
- fx2_slcs_n, fx2_slrd_n, fx2_sloe_n, fx2_slwr_n, fx2_pktend_n  out  1 each  FX2 strobes, active-low
- fx2_a  out  2  FIFO address
- fx2_db  inout  DW  FX2 data bus
- fft_weight_valid  out  1  one-cycle pulse per complex weight
- fft_weight_real, fft_weight_imag  out  DW  weight value
- fft_din_valid  out  1  input frame valid
- fft_din_busy  in  1  FFT cannot accept
- fft_din_real, fft_din_imag  out  DW*2**NPOINT  point i at [DW*i +: DW]
- fft_dout_valid  in  1  result frame valid
- fft_dout_busy  out  1  bridge cannot accept
- fft_dout_real, fft_dout_imag  in  DW*2**NPOINT  same packing

Behaviour:
- Reset values: slcs_n/slrd_n/sloe_n/slwr_n/pktend_n = 1; fx2_a = RD_EP; fx2_db released (Z); all fft_* outputs 0; fft_dout_busy = 1; state = WEIGHT.
- Constants: NW = NPOINT*2**(NPOINT-1) complex weights; NF = 2**NPOINT complex points per frame. Every complex value is two bus words: real first, then imag.
- States: WEIGHT, IDLE, RD_DIN, DIN_HOLD, WR_DOUT, PKTEND.
- Settle counter: cleared on every state entry; strobes are allowed only after SETTLE cycles in RD_* or WR_* states.
- Read beat (WEIGHT, RD_DIN): slrd_n = 0 combinationally when settled && fx2_flaga && words remain. A beat happens on each rising edge with slrd_n = 0; fx2_db is captured on that edge. sloe_n = 0 for the whole state; fx2_a = RD_EP.
- Write beat (WR_DOUT): fx2_db driven with the current word for the whole state. slwr_n = 0 when settled && fx2_flagb && words remain. A beat happens on each edge with slwr_n = 0; fx2_a = WR_EP.
- A flag low stalls the beat in progress; no word is lost or duplicated.
- slcs_n = 0 in every state except IDLE.
- WEIGHT: 2*NW beats. fft_weight_valid pulses for one cycle after each imag word, with real/imag held until the next pulse. After the last beat go to IDLE. WEIGHT is entered only from reset.
- IDLE: fft_dout_busy = 0. If fft_dout_valid: capture both dout buses, set busy = 1, go to WR_DOUT. Otherwise, if fx2_flaga, go to RD_DIN. dout has priority when both are pending.
- RD_DIN: 2*NF beats; word 2i goes to real point i, word 2i+1 to imag point i. After the last beat go to DIN_HOLD.
- DIN_HOLD: fft_din_valid = 1 with data stable. Transfer completes on an edge where valid && !fft_din_busy; valid drops the next cycle; go to IDLE.
- WR_DOUT: 2*NF beats in the same word order. After the last beat go to PKTEND.
- PKTEND: pktend_n = 0 for exactly one cycle, fx2_a = WR_EP; then go to IDLE. fft_dout_busy stays 1 from capture until back in IDLE.
- Word counters are log2-sized and cleared on state entry; no wrap within a frame.
- Reset asserted mid-operation: immediate return to reset values; the weight load restarts on deassertion.

Optional Feature:
- Macro FX2_PKTEND_EN.
- Defined: PKTEND state as described.
- Undefined: WR_DOUT goes straight to IDLE, PKTEND state is not built, fx2_pktend_n is tied 1. Suits hosts using full-packet auto-commit.

Test Plan:
- Reset, then 24 weight words 0x0001..0x0018 with flaga = 1 (NPOINT=3) -> 12 weight_valid pulses, first real=0x0001 imag=0x0002, last real=0x0017 imag=0x0018; no strobe before SETTLE=3 cycles.
- 16 frame words 0x0100..0x010F, flaga toggled low every 3rd cycle -> din_real point 0 = 0x0100, point 7 = 0x010E; din_imag point 7 = 0x010F; exactly 16 slrd_n-low edges.
- din_busy held 1 for 10 cycles after frame -> din_valid stays 1 with stable data; drops one cycle after busy falls.
- dout_valid with real[i]=i, imag[i]=0x8000+i, flagb dropped for 5 cycles mid-frame -> 16 bus words 0,0x8000,1,0x8001,...,7,0x8007 with no duplicates; one pktend_n pulse (macro on) / none (macro off).
- dout_valid and flaga both high in IDLE -> WR_DOUT entered first; RD_DIN entered after PKTEND.
- rst_n pulsed low mid-RD_DIN -> all strobes 1 and fx2_db Z immediately; weight load of 24 words required again.

Source files
------------

// File: rtl/fx2_fft_bridge.sv
`default_nettype none
// ============================================================================
// Module   : fx2_fft_bridge
// Brief    : FX2 slave-FIFO master that loads FFT twiddle weights once, then
//            streams complex frames FX2 -> FFT and results FFT -> FX2.
//            Define FX2_PKTEND_EN to build the PKTEND state after each frame.
// Revision : 2.0 - second generation, flag-qualified beats, complex words
// ============================================================================
module fx2_fft_bridge #(
  parameter int          NPOINT = 3,
  parameter int          DW     = 16,
  parameter logic [1:0]  RD_EP  = 2'b00,
  parameter logic [1:0]  WR_EP  = 2'b10,
  parameter int          SETTLE = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fx2_flaga,
  input  logic                      fx2_flagb,
  output logic                      fx2_slcs_n,
  output logic                      fx2_slrd_n,
  output logic                      fx2_sloe_n,
  output logic                      fx2_slwr_n,
  output logic                      fx2_pktend_n,
  output logic [1:0]                fx2_a,
  inout  wire  [DW-1:0]             fx2_db,
  output logic                      fft_weight_valid,
  output logic [DW-1:0]             fft_weight_real,
  output logic [DW-1:0]             fft_weight_imag,
  output logic                      fft_din_valid,
  input  logic                      fft_din_busy,
  output logic [DW*(2**NPOINT)-1:0] fft_din_real,
  output logic [DW*(2**NPOINT)-1:0] fft_din_imag,
  input  logic                      fft_dout_valid,
  output logic                      fft_dout_busy,
  input  logic [DW*(2**NPOINT)-1:0] fft_dout_real,
  input  logic [DW*(2**NPOINT)-1:0] fft_dout_imag
);

  localparam int NF        = 2**NPOINT;
  localparam int NW        = NPOINT * (2**(NPOINT-1));
  localparam int NWORD_MAX = (2*NW > 2*NF) ? 2*NW : 2*NF;
  localparam int CW        = $clog2(NWORD_MAX);
  localparam logic [CW-1:0] c_last_w = CW'(2*NW - 1);
  localparam logic [CW-1:0] c_last_f = CW'(2*NF - 1);
  localparam logic [2:0]    c_settle = 3'(SETTLE);

  typedef enum logic [2:0] {
    ST_WEIGHT,
    ST_IDLE,
    ST_RD_DIN,
    ST_DIN_HOLD,
    ST_WR_DOUT
`ifdef FX2_PKTEND_EN
    , ST_PKTEND
`endif
  } state_t;

  state_t                   r_state, w_next;
  logic [2:0]               r_settle;
  logic [CW-1:0]            r_word;
  logic                     r_live;
  logic [DW-1:0]            r_wt_re;
  logic [DW*NF-1:0]         r_dout_real, r_dout_imag;
  logic                     w_settled, w_last, w_rd_beat, w_wr_beat, w_capture;
  logic [NPOINT-1:0]        w_pt;
  logic [DW-1:0]            w_wr_word;

  assign w_settled = (r_settle == c_settle);
  assign w_last    = (r_word == ((r_state == ST_WEIGHT) ? c_last_w : c_last_f));
  assign w_rd_beat = ((r_state == ST_WEIGHT) || (r_state == ST_RD_DIN)) && w_settled && fx2_flaga;
  assign w_wr_beat = (r_state == ST_WR_DOUT) && w_settled && fx2_flagb;
  // Even words carry the real part of point word/2, odd words the imag part.
  assign w_pt      = r_word[NPOINT:1];
  assign w_wr_word = r_word[0] ? r_dout_imag[DW*w_pt +: DW] : r_dout_real[DW*w_pt +: DW];
  assign fx2_db    = (r_state == ST_WR_DOUT) ? w_wr_word : {DW{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WEIGHT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    fx2_slcs_n    = 1'b1;
    fx2_slrd_n    = 1'b1;
    fx2_sloe_n    = 1'b1;
    fx2_slwr_n    = 1'b1;
    fx2_pktend_n  = 1'b1;
    fx2_a         = RD_EP;
    fft_din_valid = 1'b0;
    fft_dout_busy = 1'b1;
    case (r_state)
      ST_WEIGHT: begin
        // Hold the bus idle for the first cycle out of reset.
        fx2_slcs_n = ~r_live;
        fx2_sloe_n = ~r_live;
        fx2_slrd_n = ~w_rd_beat;
        if (w_rd_beat && w_last) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        fft_dout_busy = 1'b0;
        if (fft_dout_valid) begin
          w_capture = 1'b1;
          w_next    = ST_WR_DOUT;
        end else if (fx2_flaga) begin
          w_next = ST_RD_DIN;
        end
      end
      ST_RD_DIN: begin
        fx2_slcs_n = 1'b0;
        fx2_sloe_n = 1'b0;
        fx2_slrd_n = ~w_rd_beat;
        if (w_rd_beat && w_last) w_next = ST_DIN_HOLD;
      end
      ST_DIN_HOLD: begin
        fx2_slcs_n    = 1'b0;
        fft_din_valid = 1'b1;
        if (!fft_din_busy) w_next = ST_IDLE;
      end
      ST_WR_DOUT: begin
        fx2_slcs_n = 1'b0;
        fx2_a      = WR_EP;
        fx2_slwr_n = ~w_wr_beat;
`ifdef FX2_PKTEND_EN
        if (w_wr_beat && w_last) w_next = ST_PKTEND;
`else
        if (w_wr_beat && w_last) w_next = ST_IDLE;
`endif
      end
`ifdef FX2_PKTEND_EN
      ST_PKTEND: begin
        fx2_slcs_n   = 1'b0;
        fx2_a        = WR_EP;
        fx2_pktend_n = 1'b0;
        w_next       = ST_IDLE;
      end
`endif
      default: w_next = ST_WEIGHT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle         <= '0;
      r_word           <= '0;
      r_live           <= 1'b0;
      r_wt_re          <= '0;
      r_dout_real      <= '0;
      r_dout_imag      <= '0;
      fft_weight_valid <= 1'b0;
      fft_weight_real  <= '0;
      fft_weight_imag  <= '0;
      fft_din_real     <= '0;
      fft_din_imag     <= '0;
    end else begin
      r_live           <= 1'b1;
      fft_weight_valid <= (r_state == ST_WEIGHT) && w_rd_beat && r_word[0];
      if (w_next != r_state) begin
        r_settle <= '0;
        r_word   <= '0;
      end else begin
        if (!w_settled) r_settle <= r_settle + 3'd1;
        if (w_rd_beat || w_wr_beat) r_word <= r_word + 1'b1;
      end
      // Real part is staged so both weight outputs change together with the pulse.
      if ((r_state == ST_WEIGHT) && w_rd_beat) begin
        if (!r_word[0]) begin
          r_wt_re <= fx2_db;
        end else begin
          fft_weight_real <= r_wt_re;
          fft_weight_imag <= fx2_db;
        end
      end
      if ((r_state == ST_RD_DIN) && w_rd_beat) begin
        if (r_word[0]) fft_din_imag[DW*w_pt +: DW] <= fx2_db;
        else           fft_din_real[DW*w_pt +: DW] <= fx2_db;
      end
      if (w_capture) begin
        r_dout_real <= fft_dout_real;
        r_dout_imag <= fft_dout_imag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fx2_fft_bridge.sv
`default_nettype none
// Directed bench for fx2_fft_bridge: FX2 FIFO model on both endpoints,
// hand-computed expectations for weights, frames, results and reset recovery.
module tb_fx2_fft_bridge;
  localparam int DW = 16;
  localparam int NF = 8;
  localparam logic [1:0] RD_EP = 2'b00;
  localparam logic [1:0] WR_EP = 2'b10;
`ifdef FX2_PKTEND_EN
  localparam int PKT_PER_FRAME = 1;
`else
  localparam int PKT_PER_FRAME = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fx2_flaga, fx2_flagb = 1'b0;
  logic fx2_slcs_n, fx2_slrd_n, fx2_sloe_n, fx2_slwr_n, fx2_pktend_n;
  logic [1:0] fx2_a;
  wire  [DW-1:0] fx2_db;
  logic fft_weight_valid;
  logic [DW-1:0] fft_weight_real, fft_weight_imag;
  logic fft_din_valid, fft_din_busy = 1'b0;
  logic [DW*NF-1:0] fft_din_real, fft_din_imag;
  logic fft_dout_valid = 1'b0, fft_dout_busy;
  logic [DW*NF-1:0] fft_dout_real = '0, fft_dout_imag = '0;

  // Host-side FIFO model
  logic [DW-1:0] out_arr [0:127];
  int            out_len = 0;
  int            out_idx = 0;
  logic          flaga_en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_arr [0:63];
  int            in_idx = 0;
  int            pkt_cnt = 0;
  logic [DW-1:0] wt_re [0:31];
  logic [DW-1:0] wt_im [0:31];
  int            wt_cnt = 0;
  int            cyc = 0;
  int            first_rd = -1;
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  assign fx2_flaga = flaga_en && (out_idx < out_len);
  assign fx2_db    = (!fx2_sloe_n && (out_idx < out_len)) ? out_arr[out_idx] : {DW{1'bz}};

  fx2_fft_bridge #(.NPOINT(3), .DW(DW), .RD_EP(RD_EP), .WR_EP(WR_EP), .SETTLE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .fx2_flaga(fx2_flaga), .fx2_flagb(fx2_flagb),
    .fx2_slcs_n(fx2_slcs_n), .fx2_slrd_n(fx2_slrd_n), .fx2_sloe_n(fx2_sloe_n),
    .fx2_slwr_n(fx2_slwr_n), .fx2_pktend_n(fx2_pktend_n), .fx2_a(fx2_a), .fx2_db(fx2_db),
    .fft_weight_valid(fft_weight_valid), .fft_weight_real(fft_weight_real),
    .fft_weight_imag(fft_weight_imag),
    .fft_din_valid(fft_din_valid), .fft_din_busy(fft_din_busy),
    .fft_din_real(fft_din_real), .fft_din_imag(fft_din_imag),
    .fft_dout_valid(fft_dout_valid), .fft_dout_busy(fft_dout_busy),
    .fft_dout_real(fft_dout_real), .fft_dout_imag(fft_dout_imag)
  );

  always @(posedge clk) begin
    if (flush) out_idx <= out_len;
    else if (!fx2_slrd_n) out_idx <= out_idx + 1;
    if (!fx2_slwr_n) begin
      in_arr[in_idx] <= fx2_db;
      in_idx <= in_idx + 1;
    end
    if (!fx2_pktend_n) pkt_cnt <= pkt_cnt + 1;
    if (fft_weight_valid) begin
      wt_re[wt_cnt] <= fft_weight_real;
      wt_im[wt_cnt] <= fft_weight_imag;
      wt_cnt <= wt_cnt + 1;
    end
    if (!rst_n) begin
      cyc <= 0;
      first_rd <= -1;
    end else begin
      cyc <= cyc + 1;
      if (!fx2_slrd_n && first_rd < 0) first_rd <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", {fx2_slcs_n, fx2_slrd_n, fx2_sloe_n, fx2_slwr_n, fx2_pktend_n}, 5'b11111);
    check("rst_addr", fx2_a, RD_EP);
    check("rst_fft", {fft_weight_valid, fft_din_valid, fft_dout_busy}, 3'b001);
    check("rst_din", fft_din_real, '0);

    // Weight load: 24 words 0x0001..0x0018
    for (int i = 0; i < 24; i++) out_arr[i] = DW'(i + 1);
    out_len = 24;
    flaga_en = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 200 && wt_cnt < 12; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("wt_pulses", wt_cnt, 12);
    check("wt_first_re", wt_re[0], 16'h0001);
    check("wt_first_im", wt_im[0], 16'h0002);
    check("wt_last_re", wt_re[11], 16'h0017);
    check("wt_last_im", wt_im[11], 16'h0018);
    check("wt_words", out_idx, 24);
    check("settle_first_rd", first_rd, 3);
    check("idle_outputs", {fx2_slcs_n, fft_dout_busy, fft_weight_real}, {1'b1, 1'b0, 16'h0017});

    // Input frame with flaga dropping every third cycle
    fft_din_busy = 1'b1;
    for (int i = 0; i < 16; i++) out_arr[24 + i] = DW'(16'h0100 + i);
    out_len = 40;
    for (int k = 0; k < 300 && !fft_din_valid; k++) begin
      flaga_en = (k % 3 != 2);
      @(negedge clk);
    end
    flaga_en = 1'b0;
    check("din_valid", fft_din_valid, 1'b1);
    check("din_rd_edges", out_idx - 24, 16);
    check("din_re0", fft_din_real[0 +: DW], 16'h0100);
    check("din_im0", fft_din_imag[0 +: DW], 16'h0101);
    check("din_re7", fft_din_real[DW*7 +: DW], 16'h010E);
    check("din_im7", fft_din_imag[DW*7 +: DW], 16'h010F);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("din_hold_valid", fft_din_valid, 1'b1);
    end
    check("din_hold_re3", fft_din_real[DW*3 +: DW], 16'h0106);
    fft_din_busy = 1'b0;
    #1 check("din_valid_until_edge", fft_din_valid, 1'b1);
    @(posedge clk); #1;
    check("din_valid_drop", fft_din_valid, 1'b0);

    // Result frame with flagb stall
    @(negedge clk);
    for (int i = 0; i < NF; i++) begin
      fft_dout_real[DW*i +: DW] = DW'(i);
      fft_dout_imag[DW*i +: DW] = DW'(16'h8000 + i);
    end
    fx2_flagb = 1'b1;
    fft_dout_valid = 1'b1;
    @(negedge clk);
    check("dout_busy_capture", fft_dout_busy, 1'b1);
    fft_dout_valid = 1'b0;
    fft_dout_real = '1;
    fft_dout_imag = '1;
    for (int k = 0; k < 100 && in_idx < 6; k++) @(negedge clk);
    fx2_flagb = 1'b0;
    repeat (5) @(negedge clk);
    check("flagb_stall", in_idx, 6);
    fx2_flagb = 1'b1;
    for (int k = 0; k < 100 && in_idx < 16; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("dout_words", in_idx, 16);
    for (int j = 0; j < 16; j++)
      check("dout_word", in_arr[j], (j % 2 == 0) ? 64'(j / 2) : 64'(16'h8000 + j / 2));
    check("pktend_count", pkt_cnt, PKT_PER_FRAME);
    check("dout_busy_idle", fft_dout_busy, 1'b0);

    // dout and flaga pending together: write first
    for (int i = 0; i < 16; i++) out_arr[40 + i] = DW'(16'h0200 + i);
    for (int i = 0; i < NF; i++) begin
      fft_dout_real[DW*i +: DW] = DW'(16'h0010 + i);
      fft_dout_imag[DW*i +: DW] = DW'(16'h0020 + i);
    end
    out_len = 56;
    flaga_en = 1'b1;
    fft_dout_valid = 1'b1;
    fft_din_busy = 1'b1;
    @(posedge clk); #1;
    check("prio_addr", fx2_a, WR_EP);
    @(negedge clk);
    fft_dout_valid = 1'b0;
    for (int k = 0; k < 200 && in_idx < 32; k++) @(negedge clk);
    check("prio_no_read", out_idx, 40);
    check("prio_w16", in_arr[16], 16'h0010);
    check("prio_w31", in_arr[31], 16'h0027);
    for (int k = 0; k < 200 && !fft_din_valid; k++) @(negedge clk);
    check("prio_din_valid", fft_din_valid, 1'b1);
    check("prio_din_re0", fft_din_real[0 +: DW], 16'h0200);
    check("prio_din_im7", fft_din_imag[DW*7 +: DW], 16'h020F);
    check("prio_pktend", pkt_cnt, 2 * PKT_PER_FRAME);
    fft_din_busy = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-frame, then full weight reload
    for (int i = 0; i < 16; i++) out_arr[56 + i] = DW'(16'h0300 + i);
    out_len = 72;
    for (int k = 0; k < 200 && out_idx < 60; k++) @(negedge clk);
    check("mid_frame_oe", fx2_sloe_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {fx2_slcs_n, fx2_slrd_n, fx2_sloe_n, fx2_slwr_n, fx2_pktend_n}, 5'b11111);
    check("mid_rst_fft", {fft_din_valid, fft_dout_busy, fft_din_real[0 +: DW]}, {1'b0, 1'b1, 16'h0000});
    flaga_en = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 24; i++) out_arr[72 + i] = DW'(16'h1001 + i);
    out_len = 96;
    flaga_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 200 && wt_cnt < 24; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("reload_pulses", wt_cnt, 24);
    check("reload_words", out_idx, 96);
    check("reload_settle", first_rd, 3);
    check("reload_first_re", wt_re[12], 16'h1001);
    check("reload_last_im", wt_im[23], 16'h1018);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
